// File: rtl/phase_sequencer.sv
// phase_sequencer: produces the FETCH/DECODE/EXECUTE/UPDATE phase stream for the
// sequence controller. It inserts RAM wait states, supports halt, run and single-step
// at instruction boundaries, and counts retired instructions.

package globe;
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    UPDATE  = 2'd3
  } STATES;
endpackage

module phase_sequencer #(
  parameter int WAIT_STATES = 1,     // extra FETCH cycles before MEM_RDY is honoured (0..15)
  parameter bit AUTO_RUN    = 1'b1,  // 1: free-run after reset, 0: start halted
  parameter int ICNT_W      = 16     // retired-instruction counter width
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RUN,
  input  logic               STEP,
  input  logic               HALT_REQ,
  input  logic               MEM_RDY,
  output globe::STATES       PHASE,
  output logic               PHASE_STB,
  output logic               HALTED,
  output logic [ICNT_W-1:0]  INSTR_CNT
);

  import globe::*;

  // MODE_STEP doubles as the step flag.
  // MODE_START is the single parked cycle after reset when AUTO_RUN=1. It is reported
  // as running, and it turns into a fresh FETCH entry at the next edge.
  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_HALT  = 2'd1,
    MODE_STEP  = 2'd2,
    MODE_START = 2'd3
  } mode_t;

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_STATES);
  localparam mode_t      RST_MODE = AUTO_RUN ? MODE_START : MODE_HALT;

  STATES             phase_r, phase_s;
  mode_t             mode_r, mode_s;
  logic [3:0]        wait_r, wait_s;
  logic              halt_pend_r, halt_pend_s;
  logic              enter_s;
  logic              wait_done_s;
  logic              stb_r, stb_s;
  logic              halted_r, halted_s;
  logic [ICNT_W-1:0] icnt_r, icnt_s;

  assign wait_done_s = (wait_r == WAIT_LIM);

  // State and output registers with synchronous active-high reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_r     <= FETCH;
      mode_r      <= RST_MODE;
      wait_r      <= 4'd0;
      halt_pend_r <= 1'b0;
      stb_r       <= 1'b0;
      halted_r    <= !AUTO_RUN;
      icnt_r      <= {ICNT_W{1'b0}};
    end else begin
      phase_r     <= phase_s;
      mode_r      <= mode_s;
      wait_r      <= wait_s;
      halt_pend_r <= halt_pend_s;
      stb_r       <= stb_s;
      halted_r    <= halted_s;
      icnt_r      <= icnt_s;
    end
  end

  // Next phase, mode, wait count and pending-halt latch
  always_comb begin
    phase_s     = phase_r;
    mode_s      = mode_r;
    wait_s      = wait_r;
    halt_pend_s = halt_pend_r;
    enter_s     = 1'b0;
    case (mode_r)
      MODE_HALT: begin
        // Parked at a boundary. HALT_REQ outranks RUN, and RUN outranks STEP.
        phase_s     = FETCH;
        wait_s      = 4'd0;
        halt_pend_s = 1'b0;
        if (HALT_REQ) begin
          mode_s = MODE_HALT;
        end else if (RUN) begin
          mode_s  = MODE_RUN;
          enter_s = 1'b1;
        end else if (STEP) begin
          mode_s  = MODE_STEP;
          enter_s = 1'b1;
        end else begin
          mode_s = MODE_HALT;
        end
      end
      MODE_START: begin
        phase_s     = FETCH;
        wait_s      = 4'd0;
        mode_s      = MODE_RUN;
        enter_s     = 1'b1;
        halt_pend_s = HALT_REQ;
      end
      MODE_RUN, MODE_STEP: begin
        if (HALT_REQ) begin
          halt_pend_s = 1'b1;
        end else begin
          halt_pend_s = halt_pend_r;
        end
        // RUN during a single step turns it into free-running. STEP while running is ignored.
        if ((mode_r == MODE_STEP) && RUN) begin
          mode_s = MODE_RUN;
        end else begin
          mode_s = mode_r;
        end
        case (phase_r)
          FETCH: begin
            if (wait_done_s && MEM_RDY) begin
              phase_s = DECODE;
              enter_s = 1'b1;
            end else if (!wait_done_s) begin
              wait_s = wait_r + 4'd1;
            end else begin
              wait_s = wait_r;
            end
          end
          DECODE: begin
            phase_s = EXECUTE;
            enter_s = 1'b1;
          end
          EXECUTE: begin
            if (MEM_RDY) begin
              phase_s = UPDATE;
              enter_s = 1'b1;
            end else begin
              phase_s = EXECUTE;
            end
          end
          UPDATE: begin
            // Instruction boundary. A HALT_REQ seen in this very cycle also stops here.
            phase_s = FETCH;
            wait_s  = 4'd0;
            if (halt_pend_r || HALT_REQ || (mode_s == MODE_STEP)) begin
              mode_s      = MODE_HALT;
              halt_pend_s = 1'b0;
            end else begin
              enter_s = 1'b1;
            end
          end
          default: begin
            phase_s = FETCH;
            wait_s  = 4'd0;
            enter_s = 1'b1;
          end
        endcase
      end
      default: begin
        mode_s      = MODE_HALT;
        phase_s     = FETCH;
        wait_s      = 4'd0;
        halt_pend_s = 1'b0;
      end
    endcase
  end

  // Next values of the strobe, halted flag and retired-instruction counter
  always_comb begin
    stb_s    = enter_s;
    halted_s = (mode_s == MODE_HALT);
    if (((mode_r == MODE_RUN) || (mode_r == MODE_STEP)) && (phase_r == UPDATE)) begin
      icnt_s = icnt_r + ICNT_W'(1);
    end else begin
      icnt_s = icnt_r;
    end
  end

  assign PHASE     = phase_r;
  assign PHASE_STB = stb_r;
  assign HALTED    = halted_r;
  assign INSTR_CNT = icnt_r;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed vectors with hand-computed expectations for three
// configurations: (WS=1, auto-run, 16-bit), (WS=1, start halted), (WS=0, 4-bit counter).

module tb_phase_sequencer;

  localparam int PF = int'(globe::FETCH);
  localparam int PD = int'(globe::DECODE);
  localparam int PE = int'(globe::EXECUTE);
  localparam int PU = int'(globe::UPDATE);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT A: WAIT_STATES=1, AUTO_RUN=1, ICNT_W=16
  logic         rst_a = 1'b1, run_a = 1'b0, step_a = 1'b0, halt_a = 1'b0, rdy_a = 1'b1;
  globe::STATES phase_a;
  logic         stb_a, halted_a;
  logic [15:0]  cnt_a;

  // DUT B: AUTO_RUN=0
  logic         rst_b = 1'b1, run_b = 1'b0, step_b = 1'b0, halt_b = 1'b0, rdy_b = 1'b1;
  globe::STATES phase_b;
  logic         stb_b, halted_b;
  logic [15:0]  cnt_b;

  // DUT C: WAIT_STATES=0, ICNT_W=4
  logic         rst_c = 1'b1, run_c = 1'b0, step_c = 1'b0, halt_c = 1'b0, rdy_c = 1'b1;
  globe::STATES phase_c;
  logic         stb_c, halted_c;
  logic [3:0]   cnt_c;

  phase_sequencer #(.WAIT_STATES(1), .AUTO_RUN(1'b1), .ICNT_W(16)) u_dut_a (
    .CLK(clk), .RST(rst_a), .RUN(run_a), .STEP(step_a), .HALT_REQ(halt_a), .MEM_RDY(rdy_a),
    .PHASE(phase_a), .PHASE_STB(stb_a), .HALTED(halted_a), .INSTR_CNT(cnt_a)
  );

  phase_sequencer #(.WAIT_STATES(1), .AUTO_RUN(1'b0), .ICNT_W(16)) u_dut_b (
    .CLK(clk), .RST(rst_b), .RUN(run_b), .STEP(step_b), .HALT_REQ(halt_b), .MEM_RDY(rdy_b),
    .PHASE(phase_b), .PHASE_STB(stb_b), .HALTED(halted_b), .INSTR_CNT(cnt_b)
  );

  phase_sequencer #(.WAIT_STATES(0), .AUTO_RUN(1'b1), .ICNT_W(4)) u_dut_c (
    .CLK(clk), .RST(rst_c), .RUN(run_c), .STEP(step_c), .HALT_REQ(halt_c), .MEM_RDY(rdy_c),
    .PHASE(phase_c), .PHASE_STB(stb_c), .HALTED(halted_c), .INSTR_CNT(cnt_c)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one cycle on DUT A and compare all of its outputs
  task automatic tick_expect(input string tag, input int ph, input int stb, input int cnt,
                             input int hlt);
    @(posedge clk);
    #1;
    check_value({tag, "_phase"},  32'(phase_a),  ph);
    check_value({tag, "_stb"},    32'(stb_a),    stb);
    check_value({tag, "_cnt"},    32'(cnt_a),    cnt);
    check_value({tag, "_halted"}, 32'(halted_a), hlt);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int t1_ph  [5];
  int t1_stb [5];
  int c_ph   [4];

  initial begin
    t1_ph  = '{PF, PF, PD, PE, PU};
    t1_stb = '{1, 0, 1, 1, 1};
    c_ph   = '{PF, PD, PE, PU};

    // ---------------- reset state of A ----------------
    tick;
    tick;
    check_value("rst_phase",  32'(phase_a),  PF);
    check_value("rst_stb",    32'(stb_a),    0);
    check_value("rst_cnt",    32'(cnt_a),    0);
    check_value("rst_halted", 32'(halted_a), 0);
    rst_a = 1'b0;

    // ---------------- 1: free run, 5 cycles per instruction ----------------
    for (int i = 0; i < 15; i++) begin
      tick_expect("t1", t1_ph[i % 5], t1_stb[i % 5], i / 5, 0);
    end
    tick_expect("t1_c15", PF, 1, 3, 0);

    // ---------------- 2: EXECUTE stall then FETCH stall ----------------
    tick_expect("t2_f", PF, 0, 3, 0);
    tick_expect("t2_d", PD, 1, 3, 0);
    for (int k = 0; k < 5; k++) begin
      tick_expect("t2_e", PE, (k == 0) ? 1 : 0, 3, 0);
      rdy_a = (k == 4);
    end
    tick_expect("t2_u", PU, 1, 3, 0);
    rdy_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick_expect("t2_fs", PF, (k == 0) ? 1 : 0, 4, 0);
      rdy_a = (k == 4);
    end
    tick_expect("t2_d2", PD, 1, 4, 0);
    tick_expect("t2_e2", PE, 1, 4, 0);
    tick_expect("t2_u2", PU, 1, 4, 0);

    // ---------------- 3: HALT_REQ pulse during DECODE ----------------
    tick_expect("t3_f", PF, 1, 5, 0);
    tick_expect("t3_f", PF, 0, 5, 0);
    tick_expect("t3_d", PD, 1, 5, 0);
    halt_a = 1'b1;
    tick_expect("t3_e", PE, 1, 5, 0);
    halt_a = 1'b0;
    tick_expect("t3_u", PU, 1, 5, 0);
    for (int k = 0; k < 20; k++) begin
      tick_expect("t3_hold", PF, 0, 6, 1);
    end

    // ---------------- 4: single step, then RUN+STEP ----------------
    step_a = 1'b1;
    tick_expect("t4_f", PF, 1, 6, 0);
    step_a = 1'b0;
    tick_expect("t4_f", PF, 0, 6, 0);
    tick_expect("t4_d", PD, 1, 6, 0);
    tick_expect("t4_e", PE, 1, 6, 0);
    tick_expect("t4_u", PU, 1, 6, 0);
    tick_expect("t4_rehalt", PF, 0, 7, 1);
    tick_expect("t4_held", PF, 0, 7, 1);
    run_a  = 1'b1;
    step_a = 1'b1;
    tick_expect("t4_rs_f", PF, 1, 7, 0);
    run_a  = 1'b0;
    step_a = 1'b0;
    tick_expect("t4_rs_f", PF, 0, 7, 0);
    tick_expect("t4_rs_d", PD, 1, 7, 0);
    step_a = 1'b1;
    tick_expect("t4_rs_e", PE, 1, 7, 0);
    step_a = 1'b0;
    tick_expect("t4_rs_u", PU, 1, 7, 0);
    tick_expect("t4_freerun", PF, 1, 8, 0);

    // ---------------- HALT_REQ in the UPDATE cycle ----------------
    tick_expect("hu_f", PF, 0, 8, 0);
    tick_expect("hu_d", PD, 1, 8, 0);
    tick_expect("hu_e", PE, 1, 8, 0);
    tick_expect("hu_u", PU, 1, 8, 0);
    halt_a = 1'b1;
    tick_expect("hu_halt", PF, 0, 9, 1);
    halt_a = 1'b0;
    tick_expect("hu_held", PF, 0, 9, 1);
    run_a = 1'b1;
    tick_expect("hu_run", PF, 1, 9, 0);
    run_a = 1'b0;
    tick_expect("hu_f", PF, 0, 9, 0);
    tick_expect("hu_d", PD, 1, 9, 0);
    tick_expect("hu_e", PE, 1, 9, 0);
    tick_expect("hu_u", PU, 1, 9, 0);
    tick_expect("hu_nolatch", PF, 1, 10, 0);

    // ---------------- 5: AUTO_RUN=0 ----------------
    check_value("t5_rst_halted", 32'(halted_b), 1);
    check_value("t5_rst_phase",  32'(phase_b),  PF);
    check_value("t5_rst_stb",    32'(stb_b),    0);
    rst_b = 1'b0;
    tick;
    check_value("t5_idle_halted", 32'(halted_b), 1);
    run_b  = 1'b1;
    halt_b = 1'b1;
    tick;
    run_b  = 1'b0;
    halt_b = 1'b0;
    check_value("t5_runhalt_halted", 32'(halted_b), 1);
    check_value("t5_runhalt_stb",    32'(stb_b),    0);
    run_b = 1'b1;
    tick;
    run_b = 1'b0;
    check_value("t5_run_halted", 32'(halted_b), 0);
    check_value("t5_run_stb",    32'(stb_b),    1);
    check_value("t5_run_phase",  32'(phase_b),  PF);
    tick;
    check_value("t5_f2_phase", 32'(phase_b), PF);
    tick;
    check_value("t5_d_phase", 32'(phase_b), PD);
    check_value("t5_d_cnt",   32'(cnt_b),   0);

    // ---------------- 6: 4-bit counter wrap, reset mid-EXECUTE ----------------
    rst_c = 1'b0;
    for (int i = 0; i <= 68; i++) begin
      tick;
      check_value("t6_phase", 32'(phase_c), c_ph[i % 4]);
      check_value("t6_stb",   32'(stb_c),   1);
      check_value("t6_cnt",   32'(cnt_c),   (i / 4) % 16);
    end
    tick;
    check_value("t6_d", 32'(phase_c), PD);
    tick;
    check_value("t6_e", 32'(phase_c), PE);
    rst_c = 1'b1;
    tick;
    check_value("t6_rst_phase", 32'(phase_c), PF);
    check_value("t6_rst_cnt",   32'(cnt_c),   0);
    check_value("t6_rst_stb",   32'(stb_c),   0);
    rst_c = 1'b0;
    tick;
    check_value("t6_restart_stb", 32'(stb_c), 1);
    check_value("t6_restart_cnt", 32'(cnt_c), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
